// File: rtl/ras_pkg.sv
// Shared types and helpers for the return-address-stack command driver.
package ras_pkg;

  typedef enum logic [1:0] {
    OTHER   = 2'd0,
    JAL     = 2'd1,
    JALR    = 2'd2,
    CBRANCH = 2'd3
  } instr_class_e;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  // ra (x1) and t0 (x5) are the only registers treated as link registers.
  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

  typedef struct packed {
    logic push;
    logic pop;
    logic branch;
    logic close_valid;
    logic close_invalid;
  } ras_cmd_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RECOVER = 2'd2
  } drv_state_e;

endpackage

// File: rtl/ras_link_decode.sv
// Classifies a decoded control-flow instruction into stack intents.
module ras_link_decode
  import ras_pkg::*;
(
  input  instr_class_e in_class,
  input  logic [4:0]   in_rd,
  input  logic [4:0]   in_rs1,
  output logic         want_push,
  output logic         want_pop,
  output logic         is_branch
);

  logic link_rd;
  logic link_rs1;

  assign link_rd  = is_link(in_rd);
  assign link_rs1 = is_link(in_rs1);

  // A JALR linking through the same register it jumps through is a call, not a
  // return, so it only pushes.
  always_comb begin
    want_push = 1'b0;
    want_pop  = 1'b0;
    is_branch = 1'b0;
    unique case (in_class)
      JAL: begin
        want_push = link_rd;
      end
      JALR: begin
        want_push = link_rd;
        want_pop  = link_rs1 && !(link_rd && (in_rd == in_rs1));
      end
      CBRANCH: begin
        is_branch = 1'b1;
      end
      default: begin
        want_push = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ras_driver.sv
// Issuing side of the return-address stack: turns decoded control flow and
// branch resolutions into single-cycle stack commands.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_RUN     | normal issue; resolutions accepted
// ST_HOLD    | one cycle after close_valid; resolutions held, issue continues
// ST_RECOVER | one cycle after close_invalid; nothing accepted, count cleared
module ras_driver
  import ras_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int MAX_BRANCHES = 128,
  localparam int CNT_W       = $clog2(MAX_BRANCHES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [1:0]       in_class,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic             in_compressed,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic             res_mispredict,
  output logic             ras_push,
  output logic             ras_pop,
  output logic             ras_branch,
  output logic             ras_close_valid,
  output logic             ras_close_invalid,
  output logic [WIDTH-1:0] ras_din,
  input  logic [WIDTH-1:0] ras_dout,
  input  logic             ras_empty,
  output logic             pred_valid,
  output logic [WIDTH-1:0] pred_target,
  output logic [CNT_W-1:0] outstanding
);

  drv_state_e       state_q, state_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             pred_valid_q, pred_valid_d;
  ras_cmd_t         cmd;

  logic             want_push;
  logic             want_pop;
  logic             is_branch;
  logic             full;
  logic             accept;
  logic [WIDTH-1:0] ret_addr;

  ras_link_decode u_decode (
    .in_class  (instr_class_e'(in_class)),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .want_push (want_push),
    .want_pop  (want_pop),
    .is_branch (is_branch)
  );

  assign full     = (outstanding_q == CNT_W'(MAX_BRANCHES));
  assign ret_addr = in_pc + (in_compressed ? WIDTH'(2) : WIDTH'(4));

  // Next state, handshakes, stack commands and the unresolved-branch count.
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    cmd           = '0;
    in_ready      = 1'b1;
    res_ready     = 1'b0;
    accept        = 1'b0;
    pred_valid_d  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        res_ready = 1'b1;
        // A resolution with nothing outstanding is ignored (protocol error).
        if (res_valid && (outstanding_q != '0)) begin
          if (res_mispredict) begin
            cmd.close_invalid = 1'b1;
            in_ready          = 1'b0;
            state_d           = ST_RECOVER;
          end else begin
            cmd.close_valid = 1'b1;
            state_d         = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        state_d = ST_RUN;
      end
      ST_RECOVER: begin
        in_ready = 1'b0;
        state_d  = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (full && is_branch) begin
      in_ready = 1'b0;
    end

    accept     = in_valid && in_ready;
    cmd.push   = accept && want_push;
    cmd.pop    = accept && want_pop && !ras_empty;
    cmd.branch = accept && is_branch;

    if (state_q == ST_RECOVER) begin
      outstanding_d = '0;
    end else begin
      outstanding_d = outstanding_q + CNT_W'(cmd.branch) - CNT_W'(cmd.close_valid);
    end

    pred_valid_d = cmd.pop;
  end

  // State, branch count and the one-cycle pop-to-prediction pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      outstanding_q <= '0;
      pred_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      pred_valid_q  <= pred_valid_d;
    end
  end

  assign ras_push          = cmd.push;
  assign ras_pop           = cmd.pop;
  assign ras_branch        = cmd.branch;
  assign ras_close_valid   = cmd.close_valid;
  assign ras_close_invalid = cmd.close_invalid;
  assign ras_din           = cmd.push ? ret_addr : '0;
  assign pred_valid        = pred_valid_q;
  assign pred_target       = pred_valid_q ? ras_dout : '0;
  assign outstanding       = outstanding_q;

  res_with_none_outstanding: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(res_valid && res_ready && (outstanding_q == '0))
  );

endmodule

// File: tb/tb_ras_driver.sv
// Scoreboard bench for ras_driver: directed vectors push expected per-cycle
// observations; a negedge monitor pops and compares whenever the DUT is active.
module tb_ras_driver;
  import ras_pkg::*;

  localparam int W  = 32;
  localparam int MB = 128;
  localparam int CW = $clog2(MB + 1);

  localparam logic [4:0] C_PUSH = 5'b10000;
  localparam logic [4:0] C_POP  = 5'b01000;
  localparam logic [4:0] C_BR   = 5'b00100;
  localparam logic [4:0] C_CV   = 5'b00010;
  localparam logic [4:0] C_CI   = 5'b00001;

  typedef struct packed {
    logic [4:0]   cmd;
    logic [W-1:0] din;
    logic         pv;
    logic [W-1:0] pt;
  } obs_t;

  localparam obs_t NONE = '0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_pc;
  logic [1:0]    in_class;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic          in_compressed;
  logic          res_valid;
  logic          res_ready;
  logic          res_mispredict;
  logic          ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
  logic [W-1:0]  ras_din;
  logic [W-1:0]  ras_dout;
  logic          ras_empty;
  logic          pred_valid;
  logic [W-1:0]  pred_target;
  logic [CW-1:0] outstanding;

  obs_t exp_q[$];
  obs_t mon_a, mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  ras_driver #(.WIDTH(W), .MAX_BRANCHES(MB)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_pc             (in_pc),
    .in_class          (in_class),
    .in_rd             (in_rd),
    .in_rs1            (in_rs1),
    .in_compressed     (in_compressed),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_mispredict    (res_mispredict),
    .ras_push          (ras_push),
    .ras_pop           (ras_pop),
    .ras_branch        (ras_branch),
    .ras_close_valid   (ras_close_valid),
    .ras_close_invalid (ras_close_invalid),
    .ras_din           (ras_din),
    .ras_dout          (ras_dout),
    .ras_empty         (ras_empty),
    .pred_valid        (pred_valid),
    .pred_target       (pred_target),
    .outstanding       (outstanding)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [4:0] c, input logic [W-1:0] d,
                              input logic p, input logic [W-1:0] t);
    obs_t o;
    o.cmd = c;
    o.din = d;
    o.pv  = p;
    o.pt  = t;
    return o;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; called just after a rising edge.
  task automatic step(input logic iv, input logic [1:0] cls, input logic [W-1:0] pc,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic comp,
                      input logic rv, input logic rm,
                      input logic exp_ir, input logic exp_rr, input obs_t e);
    in_valid       = iv;
    in_class       = cls;
    in_pc          = pc;
    in_rd          = rd;
    in_rs1         = rs1;
    in_compressed  = comp;
    res_valid      = rv;
    res_mispredict = rm;
    if (e != NONE) exp_q.push_back(e);
    @(negedge clk);
    chk("in_ready", W'(in_ready), W'(exp_ir));
    chk("res_ready", W'(res_ready), W'(exp_rr));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic exp_ir, input logic exp_rr, input obs_t e);
    step(1'b0, OTHER, '0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ir, exp_rr, e);
  endtask

  // Scoreboard monitor: every active DUT cycle must match the next expectation.
  always @(negedge clk) begin
    if (reset_n && (({ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid} != 5'd0)
                    || pred_valid)) begin
      mon_a = mk({ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid},
                 ras_din, pred_valid, pred_target);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got cmd=%b din=0x%h pv=%b pt=0x%h, expected no activity",
                 mon_a.cmd, mon_a.din, mon_a.pv, mon_a.pt);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          miscompares++;
          $display("FAIL scoreboard: got cmd=%b din=0x%h pv=%b pt=0x%h, expected cmd=%b din=0x%h pv=%b pt=0x%h",
                   mon_a.cmd, mon_a.din, mon_a.pv, mon_a.pt,
                   mon_e.cmd, mon_e.din, mon_e.pv, mon_e.pt);
        end
      end
    end
  end

  initial begin
    reset_n        = 1'b0;
    in_valid       = 1'b0;
    in_pc          = '0;
    in_class       = OTHER;
    in_rd          = 5'd0;
    in_rs1         = 5'd0;
    in_compressed  = 1'b0;
    res_valid      = 1'b0;
    res_mispredict = 1'b0;
    ras_dout       = '0;
    ras_empty      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_res_ready", W'(res_ready), W'(1));
    chk("rst_outstanding", W'(outstanding), W'(0));
    chk("rst_pred_valid", W'(pred_valid), W'(0));
    chk("rst_cmds", W'({ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid}), W'(0));
    chk("rst_din", ras_din, W'(0));
    @(posedge clk);
    #1;

    // Call then return: push 0x104, pop, prediction one cycle later
    ras_empty = 1'b0;
    ras_dout  = 32'h0000_0104;
    step(1, JAL,  32'h100, 5'd1, 5'd0, 0, 0, 0, 1, 1, mk(C_PUSH, 32'h104, 0, '0));
    step(1, JALR, 32'h180, 5'd0, 5'd1, 0, 0, 0, 1, 1, mk(C_POP, '0, 0, '0));
    idle(1, 1, mk(5'd0, '0, 1, 32'h104));

    // Compressed return address wraps
    step(1, JAL, 32'hFFFF_FFFE, 5'd5, 5'd0, 1, 0, 0, 1, 1, mk(C_PUSH, 32'h0, 0, '0));

    // Coroutine swap: push and pop together, prediction is prior top
    ras_dout = 32'h0000_0ABC;
    step(1, JALR, 32'h200, 5'd5, 5'd1, 0, 0, 0, 1, 1, mk(C_PUSH | C_POP, 32'h204, 0, '0));
    idle(1, 1, mk(5'd0, '0, 1, 32'hABC));
    step(1, JALR, 32'h300, 5'd1, 5'd1, 0, 0, 0, 1, 1, mk(C_PUSH, 32'h304, 0, '0));

    // Pop against an empty stack, and non-linking jumps: no activity
    ras_empty = 1'b1;
    step(1, JALR, 32'h340, 5'd0, 5'd5, 0, 0, 0, 1, 1, NONE);
    idle(1, 1, NONE);
    ras_empty = 1'b0;
    step(1, JAL,  32'h380, 5'd0, 5'd0, 0, 0, 0, 1, 1, NONE);
    step(1, JALR, 32'h3C0, 5'd2, 5'd3, 0, 0, 0, 1, 1, NONE);

    // Fill the branch FIFO, then one more branch stalls while a JAL passes
    for (int i = 0; i < MB; i++) begin
      step(1, CBRANCH, W'(32'h1000 + i * 4), 5'd0, 5'd0, 0, 0, 0, 1, 1, mk(C_BR, '0, 0, '0));
    end
    chk("outstanding_full", W'(outstanding), W'(128));
    step(1, CBRANCH, 32'h2000, 5'd0, 5'd0, 0, 0, 0, 0, 1, NONE);
    step(1, JAL, 32'h400, 5'd1, 5'd0, 0, 0, 0, 1, 1, mk(C_PUSH, 32'h404, 0, '0));
    chk("outstanding_after_stall", W'(outstanding), W'(128));

    // Back-to-back good resolutions: close_valid at N and N+2
    step(0, OTHER, '0, 5'd0, 5'd0, 0, 1, 0, 1, 1, mk(C_CV, '0, 0, '0));
    step(0, OTHER, '0, 5'd0, 5'd0, 0, 1, 0, 1, 0, NONE);
    step(0, OTHER, '0, 5'd0, 5'd0, 0, 1, 0, 1, 1, mk(C_CV, '0, 0, '0));
    idle(1, 0, NONE);
    chk("outstanding_two_closed", W'(outstanding), W'(126));

    // Branch and close_valid together, then a JAL accepted during HOLD
    step(1, CBRANCH, 32'h600, 5'd0, 5'd0, 0, 1, 0, 1, 1, mk(C_BR | C_CV, '0, 0, '0));
    step(1, JAL, 32'h700, 5'd1, 5'd0, 0, 0, 0, 1, 0, mk(C_PUSH, 32'h704, 0, '0));
    chk("outstanding_br_and_close", W'(outstanding), W'(126));

    // Mispredict clears everything
    step(0, OTHER, '0, 5'd0, 5'd0, 0, 1, 1, 0, 1, mk(C_CI, '0, 0, '0));
    idle(0, 0, NONE);
    chk("outstanding_after_recover", W'(outstanding), W'(0));

    // Three branches, then mispredict alongside a JAL: close_invalid only
    for (int i = 0; i < 3; i++) begin
      step(1, CBRANCH, W'(32'h800 + i * 4), 5'd0, 5'd0, 0, 0, 0, 1, 1, mk(C_BR, '0, 0, '0));
    end
    chk("outstanding_three", W'(outstanding), W'(3));
    step(1, JAL, 32'h500, 5'd1, 5'd0, 0, 1, 1, 0, 1, mk(C_CI, '0, 0, '0));
    step(1, JAL, 32'h500, 5'd1, 5'd0, 0, 0, 0, 0, 0, NONE);
    chk("outstanding_cleared", W'(outstanding), W'(0));
    step(1, JAL, 32'h500, 5'd1, 5'd0, 0, 0, 0, 1, 1, mk(C_PUSH, 32'h504, 0, '0));

    // Asynchronous reset mid-operation
    step(1, CBRANCH, 32'h900, 5'd0, 5'd0, 0, 0, 0, 1, 1, mk(C_BR, '0, 0, '0));
    step(1, CBRANCH, 32'h904, 5'd0, 5'd0, 0, 0, 0, 1, 1, mk(C_BR, '0, 0, '0));
    chk("outstanding_pre_reset", W'(outstanding), W'(2));
    in_valid = 1'b0;
    in_class = OTHER;
    reset_n  = 1'b0;
    #1;
    chk("async_reset_outstanding", W'(outstanding), W'(0));
    chk("async_reset_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1, 1, NONE);

    repeat (3) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expectations: got %0d unmatched, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
